search_scheduler: RTL
=====================

Name: search_scheduler

Overview:
- Work scheduler for the brute-force MD5 search.
- Splits the COUNT_W-bit candidate space into fixed-size chunks and hands them to NUM_ENGINES counter+pipeline engines over a start/busy handshake.
- Collects found reports, stops all engines on the first hit and presents the winning candidate to the display and LED logic.
- Sits between the top-level driver controls (enable switch, reset button) and the engine array.

Parameters:
NUM_ENGINES, 4, number of engines; a power of two from 1 to 16.
COUNT_W, 32, candidate counter width.
CHUNK_BITS, 16, log2 of the chunk size; must be less than COUNT_W.
ENG_W, 2, engine index width; equals log2(NUM_ENGINES) with a minimum of 1.

Ports:
CLK  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  run/pause; when 0, no new chunks are issued.
eng_busy  in  NUM_ENGINES  engine i is processing a chunk; it rises the cycle after eng_start[i].
eng_found  in  NUM_ENGINES  level; engine i has matched the target.
eng_found_value  in  NUM_ENGINES*COUNT_W  matching candidate of engine i; slice i holds bits [i*COUNT_W +: COUNT_W]; valid while eng_found[i] is 1.
eng_start  out  NUM_ENGINES  one-hot, single-cycle pulse that loads a chunk.
eng_base  out  COUNT_W  chunk base; valid in the cycle eng_start is non-zero.
eng_abort  out  1  level; all engines stop.
running  out  1  state is DISPATCH or DRAIN.
done  out  1  space exhausted with no match; sticky.
found  out  1  match latched; sticky.
found_value  out  COUNT_W  latched matching candidate.
found_engine  out  ENG_W  index of the engine that reported the match.
chunks_issued  out  COUNT_W-CHUNK_BITS+1  number of chunks dispatched so far.

Behaviour:
Reset values:
- All outputs are 0; state is IDLE.
- Internal state: next_base=0, exhausted=0, rr_ptr=0, started_mask=0.
- Reset takes priority over every other event, in any state.

States:
- IDLE: if enable=1, go to DISPATCH next cycle. Found inputs are ignored in IDLE.
- DISPATCH:
  - Priority 1: any eng_found bit set -> capture and go to FOUND.
  - Priority 2: exhausted=1 -> go to DRAIN.
  - Priority 3: if enable=1 and at least one engine is free, issue one chunk.
- DRAIN:
  - Any eng_found bit set -> FOUND.
  - Otherwise, when eng_busy=0 and started_mask=0 -> DONE.
- FOUND: terminal. found=1, eng_abort=1, running=0. Exit only through reset.
- DONE: terminal. done=1, running=0, eng_abort=0. Exit only through reset.

Dispatch rules (DISPATCH state only):
- free[i] = ~eng_busy[i] & ~started_mask[i]. started_mask[i] is set in the cycle eng_start[i] pulses and cleared the following cycle, which covers the one-cycle busy lag.
- Round-robin selection: choose the first free engine at or after rr_ptr, wrapping modulo NUM_ENGINES.
- In the same cycle:
  - pulse eng_start[sel];
  - drive eng_base = next_base;
  - next_base += 2^CHUNK_BITS;
  - rr_ptr = sel+1 mod NUM_ENGINES;
  - chunks_issued += 1.
- At most one chunk is issued per cycle.
- Wrap-around: if the next_base increment carries out of COUNT_W, set exhausted=1 and let next_base wrap to 0. No chunk is ever issued twice.
- Outside a dispatch cycle, eng_start=0 and eng_base holds its last value.

Pause:
- enable=0 in DISPATCH stops issue only.
- In-flight engines continue and found reports are still captured.
- enable has no effect in DRAIN, FOUND or DONE.

Found capture (one cycle):
- When several eng_found bits are set in the same cycle, the lowest index wins.
- found_value = that engine's slice of eng_found_value; found_engine = that index.
- found, eng_abort, found_value and found_engine assert the cycle after capture and never change until reset.
- A found report in the same cycle as a dispatch opportunity wins; no chunk is issued that cycle.

Latency:
- enable rise in IDLE -> first eng_start in 2 cycles.
- eng_found rise -> found and eng_abort in 1 cycle.

Test Plan:
1. Sweep, no match (COUNT_W=8, CHUNK_BITS=4, NUM_ENGINES=4; each engine's busy lasts 3 cycles) -> 16 starts with bases 0x00..0xF0 in order; engines selected round-robin 0,1,2,3,0,…; chunks_issued=16; done=1 after the last busy falls; found=0.
2. Single match: engine 2 asserts eng_found with value 0x5A during the 6th chunk -> found=1 and found_value=0x5A in the next cycle; found_engine=2; eng_abort=1; no further eng_start.
3. Simultaneous match: engines 1 and 3 found in the same cycle, values 0x11 and 0x33 -> found_engine=1, found_value=0x11.
4. Pause: enable drops after 5 chunks and is held low 20 cycles -> no eng_start during the pause; chunks_issued stays 5; issue resumes at base 0x50.
5. Match while draining: eng_found on engine 0 after the last chunk (0xF0) is issued, while still busy -> FOUND, not DONE; done=0.
6. Reset mid-run: reset after chunk 7 -> all outputs 0 next cycle; with enable held at 1, the next eng_start drives base 0x00 on engine 0.

Source files
------------

// File: rtl/search_scheduler.sv
// search_scheduler: hands fixed-size chunks of the candidate space to an array
// of counter+pipeline search engines, watches their found reports, and latches
// the first winning candidate for the display/LED logic.
//
// Start/busy handshake (engine side):
//   eng_start[i] is a one-cycle, one-hot pulse. eng_base is valid in that cycle.
//   The engine samples the pulse on the next rising edge and raises eng_busy[i]
//   from the following cycle. It keeps eng_busy[i] high until its chunk is done.
//   started_mask[i] covers the one cycle between the pulse and busy rising. In
//   that cycle engine i cannot be picked again.
//   eng_found[i] is a level. eng_found_value slice i is only meaningful while it
//   is high. eng_abort is a level that tells every engine to stop.
module search_scheduler #(
    parameter int NUM_ENGINES = 4,
    parameter int COUNT_W     = 32,
    parameter int CHUNK_BITS  = 16,
    parameter int ENG_W       = 2
) (
    input  logic                           CLK,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [NUM_ENGINES-1:0]         eng_busy,
    input  logic [NUM_ENGINES-1:0]         eng_found,
    input  logic [NUM_ENGINES*COUNT_W-1:0] eng_found_value,
    output logic [NUM_ENGINES-1:0]         eng_start,
    output logic [COUNT_W-1:0]             eng_base,
    output logic                           eng_abort,
    output logic                           running,
    output logic                           done,
    output logic                           found,
    output logic [COUNT_W-1:0]             found_value,
    output logic [ENG_W-1:0]               found_engine,
    output logic [COUNT_W-CHUNK_BITS:0]    chunks_issued
);

    localparam int CNT_W = COUNT_W - CHUNK_BITS + 1;
    // The selector walks a power-of-two index space. For a single engine that
    // space is 2 entries, and the unused entry is never free.
    localparam int SEL_N = 1 << ENG_W;
    localparam bit SINGLE_ENGINE = (NUM_ENGINES == 1);
    localparam logic [COUNT_W:0] CHUNK_INC = {{COUNT_W{1'b0}}, 1'b1} << CHUNK_BITS;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DISPATCH = 3'd1,
        DRAIN    = 3'd2,
        FOUND    = 3'd3,
        DONE     = 3'd4
    } state_t;

    // Current FSM state. It is kept as a named signal so that checkers can bind to it.
    state_t state;

    logic [COUNT_W-1:0]     next_base;
    logic                   exhausted;
    logic [ENG_W-1:0]       rr_ptr;
    logic [NUM_ENGINES-1:0] started_mask;

    logic [SEL_N-1:0]       free_ext;
    logic [ENG_W-1:0]       cand;
    logic [ENG_W-1:0]       sel;
    logic                   sel_valid;
    logic [NUM_ENGINES-1:0] sel_onehot;

    logic                   hit;
    logic [ENG_W-1:0]       hit_idx;
    logic [COUNT_W-1:0]     hit_value;

    logic [COUNT_W:0]       base_sum;

    // Round-robin pick: the first free engine at or after rr_ptr, wrapping around.
    always_comb begin
        free_ext = '0;
        free_ext[NUM_ENGINES-1:0] = ~eng_busy & ~started_mask;
        cand      = '0;
        sel       = '0;
        sel_valid = 1'b0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            cand = rr_ptr + ENG_W'(k);
            if (!sel_valid && free_ext[cand]) begin
                sel_valid = 1'b1;
                sel       = cand;
            end
        end
    end

    // One-hot form of the selected engine. It drives eng_start and started_mask.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            sel_onehot[i] = (ENG_W'(i) == sel);
        end
    end

    // Found priority encoder: when several engines report together, the lowest index wins.
    always_comb begin
        hit       = |eng_found;
        hit_idx   = '0;
        hit_value = '0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            if (eng_found[i]) begin
                hit_idx   = ENG_W'(i);
                hit_value = eng_found_value[i*COUNT_W +: COUNT_W];
            end
        end
    end

    // Next chunk base. The extra top bit is the carry that marks the space as exhausted.
    always_comb begin
        base_sum = {1'b0, next_base} + CHUNK_INC;
    end

    // Scheduler FSM. It also holds all registered outputs.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state         <= IDLE;
            next_base     <= '0;
            exhausted     <= 1'b0;
            rr_ptr        <= '0;
            started_mask  <= '0;
            eng_start     <= '0;
            eng_base      <= '0;
            eng_abort     <= 1'b0;
            running       <= 1'b0;
            done          <= 1'b0;
            found         <= 1'b0;
            found_value   <= '0;
            found_engine  <= '0;
            chunks_issued <= '0;
        end else begin
            // Start pulses and the busy-lag mask last exactly one cycle.
            eng_start    <= '0;
            started_mask <= '0;

            case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= DISPATCH;
                        running <= 1'b1;
                    end
                end

                DISPATCH: begin
                    if (hit) begin
                        // A found report beats any dispatch opportunity in the same cycle.
                        state        <= FOUND;
                        found        <= 1'b1;
                        eng_abort    <= 1'b1;
                        running      <= 1'b0;
                        found_value  <= hit_value;
                        found_engine <= hit_idx;
                    end else if (exhausted) begin
                        state <= DRAIN;
                    end else if (enable && sel_valid) begin
                        eng_start     <= sel_onehot;
                        started_mask  <= sel_onehot;
                        eng_base      <= next_base;
                        next_base     <= base_sum[COUNT_W-1:0];
                        chunks_issued <= chunks_issued + CNT_W'(1);
                        rr_ptr        <= SINGLE_ENGINE ? '0 : sel + ENG_W'(1);
                        if (base_sum[COUNT_W]) begin
                            exhausted <= 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    if (hit) begin
                        state        <= FOUND;
                        found        <= 1'b1;
                        eng_abort    <= 1'b1;
                        running      <= 1'b0;
                        found_value  <= hit_value;
                        found_engine <= hit_idx;
                    end else if ((eng_busy == '0) && (started_mask == '0)) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        running <= 1'b0;
                    end
                end

                FOUND: begin
                    // Terminal state. Only reset leaves it.
                end

                DONE: begin
                    // Terminal state. Only reset leaves it.
                end

                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule
